// File: rtl/icache_ifill_ctrl.sv
// rtl/icache_ifill_ctrl.sv - L1 instruction-cache line refill controller with out-of-order beat assembly and kill/drain
module icache_ifill_ctrl #(
    parameter int PADDR_SIZE = 26,
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 64,
    parameter int N_WAY      = 4,
    parameter int OFFSET_W   = $clog2(LINE_WIDTH / 8),
    localparam int N_BEATS    = LINE_WIDTH / BEAT_WIDTH,
    localparam int WAY_W      = (N_WAY > 1) ? $clog2(N_WAY) : 1,
    localparam int BEAT_IDX_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [PADDR_SIZE-1:0] req_paddr_i,
    input  logic [WAY_W-1:0]      req_way_i,
    input  logic                  kill_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PADDR_SIZE-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [BEAT_IDX_W-1:0] mem_resp_beat_i,
    input  logic [BEAT_WIDTH-1:0] mem_resp_data_i,
    output logic                  fill_valid_o,
    output logic [WAY_W-1:0]      fill_way_o,
    output logic [PADDR_SIZE-1:0] fill_paddr_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  busy_o
);

    // Clears the byte-offset bits so every memory request is line aligned.
    localparam logic [PADDR_SIZE-1:0] ADDR_MASK = {PADDR_SIZE{1'b1}} << OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FILL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [N_BEATS-1:0]      mask_q, mask_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [PADDR_SIZE-1:0]   addr_q, addr_d;
    logic [WAY_W-1:0]        way_q, way_d;

    logic [N_BEATS-1:0]      beat_oh;
    logic [N_BEATS-1:0]      mask_upd;
    logic                    mask_done;

    // Decode the incoming beat index; out-of-range indices select no slot.
    always_comb begin
        beat_oh = '0;
        for (int i = 0; i < N_BEATS; i++) begin
            if (mem_resp_valid_i && (mem_resp_beat_i == BEAT_IDX_W'(i))) begin
                beat_oh[i] = 1'b1;
            end
        end
        mask_upd  = mask_q | beat_oh;
        mask_done = mem_resp_valid_i && (&mask_upd);
    end

    // State register and refill datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            way_q   <= way_d;
        end
    end

    // Next-state logic: accept, request handshake, beat assembly, drain after kill.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        line_d  = line_q;
        addr_d  = addr_q;
        way_d   = way_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !kill_i) begin
                    addr_d  = req_paddr_i & ADDR_MASK;
                    way_d   = req_way_i;
                    mask_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once the request is accepted, beats are owed and must be drained.
                if (mem_req_ready_i) begin
                    state_d = kill_i ? ST_DRAIN : ST_FILL;
                end else if (kill_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (mem_resp_valid_i) begin
                    mask_d = mask_upd;
                    for (int i = 0; i < N_BEATS; i++) begin
                        if (beat_oh[i]) begin
                            line_d[i*BEAT_WIDTH +: BEAT_WIDTH] = mem_resp_data_i;
                        end
                    end
                end
                if (mask_done) begin
                    state_d = kill_i ? ST_IDLE : ST_WRITE;
                end else if (kill_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_resp_valid_i) begin
                    mask_d = mask_upd;
                end
                if (mask_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode purely from state and registers.
    always_comb begin
        req_ready_o     = (state_q == ST_IDLE);
        mem_req_valid_o = (state_q == ST_REQ);
        mem_req_addr_o  = addr_q;
        fill_valid_o    = (state_q == ST_WRITE);
        fill_way_o      = way_q;
        fill_paddr_o    = addr_q;
        fill_data_o     = line_q;
        busy_o          = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_icache_ifill_ctrl.sv
// tb/tb_icache_ifill_ctrl.sv - scoreboard bench for icache_ifill_ctrl in 128/64/4-way and 512/128/8-way builds
module tb_icache_ifill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    bit           cfg = 1'b0;
    int           cyc = 0;
    logic         req_valid = 1'b0;
    logic [25:0]  req_paddr = '0;
    logic [2:0]   req_way = '0;
    logic         kill = 1'b0;
    logic         mem_req_ready = 1'b0;
    logic         resp_valid = 1'b0;
    logic [1:0]   resp_beat = '0;
    logic [127:0] resp_data = '0;

    logic         v0_req, v0_rdy, v0_resp, v1_req, v1_rdy, v1_resp;
    logic         r0_ready, r0_mvalid, r0_fvalid, r0_busy;
    logic [25:0]  r0_maddr, r0_fpaddr;
    logic [1:0]   r0_fway;
    logic [127:0] r0_fdata;
    logic         r1_ready, r1_mvalid, r1_fvalid, r1_busy;
    logic [25:0]  r1_maddr, r1_fpaddr;
    logic [2:0]   r1_fway;
    logic [511:0] r1_fdata;

    logic         m_ready, m_mvalid, m_fvalid, m_busy;
    logic [25:0]  m_maddr, m_fpaddr;
    logic [2:0]   m_fway;
    logic [511:0] m_fdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   way;
        logic [25:0]  pa;
        logic [511:0] data;
        int           cyc;
    } exp_t;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [25:0]  exp_maddr = '0;

    int           ord[8];
    logic [127:0] dat[8];
    int           n_ord;

    assign v0_req  = req_valid && !cfg;
    assign v0_rdy  = mem_req_ready && !cfg;
    assign v0_resp = resp_valid && !cfg;
    assign v1_req  = req_valid && cfg;
    assign v1_rdy  = mem_req_ready && cfg;
    assign v1_resp = resp_valid && cfg;

    icache_ifill_ctrl dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v0_req), .req_ready_o(r0_ready),
        .req_paddr_i(req_paddr), .req_way_i(req_way[1:0]), .kill_i(kill),
        .mem_req_valid_o(r0_mvalid), .mem_req_ready_i(v0_rdy), .mem_req_addr_o(r0_maddr),
        .mem_resp_valid_i(v0_resp), .mem_resp_beat_i(resp_beat[0]), .mem_resp_data_i(resp_data[63:0]),
        .fill_valid_o(r0_fvalid), .fill_way_o(r0_fway), .fill_paddr_o(r0_fpaddr),
        .fill_data_o(r0_fdata), .busy_o(r0_busy)
    );

    icache_ifill_ctrl #(.LINE_WIDTH(512), .BEAT_WIDTH(128), .N_WAY(8)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v1_req), .req_ready_o(r1_ready),
        .req_paddr_i(req_paddr), .req_way_i(req_way), .kill_i(kill),
        .mem_req_valid_o(r1_mvalid), .mem_req_ready_i(v1_rdy), .mem_req_addr_o(r1_maddr),
        .mem_resp_valid_i(v1_resp), .mem_resp_beat_i(resp_beat), .mem_resp_data_i(resp_data),
        .fill_valid_o(r1_fvalid), .fill_way_o(r1_fway), .fill_paddr_o(r1_fpaddr),
        .fill_data_o(r1_fdata), .busy_o(r1_busy)
    );

    always_comb begin
        m_ready  = cfg ? r1_ready  : r0_ready;
        m_mvalid = cfg ? r1_mvalid : r0_mvalid;
        m_maddr  = cfg ? r1_maddr  : r0_maddr;
        m_fvalid = cfg ? r1_fvalid : r0_fvalid;
        m_fway   = cfg ? r1_fway   : {1'b0, r0_fway};
        m_fpaddr = cfg ? r1_fpaddr : r0_fpaddr;
        m_fdata  = cfg ? r1_fdata  : {384'b0, r0_fdata};
        m_busy   = cfg ? r1_busy   : r0_busy;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: request address whenever a request is presented, fills popped from the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_mvalid) chk("mem_req_addr", {486'b0, m_maddr}, {486'b0, exp_maddr});
            if (m_fvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fill cyc=%0d way=%0d paddr=%0h required no fill", cyc, m_fway, m_fpaddr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("fill_way", {509'b0, m_fway}, {509'b0, mon_e.way});
                    chk("fill_paddr", {486'b0, m_fpaddr}, {486'b0, mon_e.pa});
                    chk("fill_data", m_fdata, mon_e.data);
                    chk("fill_cycle", 512'(cyc), 512'(mon_e.cyc));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", {511'b0, m_busy}, 512'd0);
    endtask

    task automatic make_order(input bit dup);
        int nb = cfg ? 4 : 2;
        int j, t;
        n_ord = nb;
        for (int i = 0; i < nb; i++) ord[i] = i;
        for (int i = nb - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < nb + 1; i++) dat[i] = {$urandom, $urandom, $urandom, $urandom};
        if (dup) begin
            ord[n_ord] = ord[n_ord-1];
            ord[n_ord-1] = ord[0];
            n_ord++;
        end
    endtask

    // modes: 0 normal, 1 kill at accept, 2 kill in REQ no ready, 3 kill with ready,
    // 4 kill in FILL after first beat, 5 kill with completing beat, 6 kill in WRITE, 7 reset in FILL
    task automatic run_txn(input int mode, input logic [25:0] pa, input logic [2:0] wy,
                           input int d, input bit gaps);
        int           nb = cfg ? 4 : 2;
        int           bw = cfg ? 128 : 64;
        int           off = cfg ? 6 : 4;
        int           c0, t_last;
        logic [511:0] line = '0;
        logic [511:0] bmask = cfg ? {384'b0, {128{1'b1}}} : {448'b0, {64{1'b1}}};
        logic [25:0]  la = (pa >> off) << off;
        logic [2:0]   ew = cfg ? wy : (wy & 3'd3);
        exp_t         e;
        wait_idle();
        exp_maddr = la;
        c0 = cyc;
        req_valid = 1'b1; req_paddr = pa; req_way = wy; kill = (mode == 1);
        step();
        req_valid = 1'b0; kill = 1'b0;
        if (mode == 1) begin
            chk("kill_at_accept_busy", {511'b0, m_busy}, 512'd0);
            return;
        end
        chk("mem_req_valid", {511'b0, m_mvalid}, 512'd1);
        repeat (d) step();
        if (mode == 2) begin
            chk("req_held_valid", {511'b0, m_mvalid}, 512'd1);
            kill = 1'b1;
            step();
            kill = 1'b0;
            chk("kill_req_busy", {511'b0, m_busy}, 512'd0);
            chk("kill_req_ready", {511'b0, m_ready}, 512'd1);
            return;
        end
        mem_req_ready = 1'b1; kill = (mode == 3);
        step();
        mem_req_ready = 1'b0; kill = 1'b0;
        chk("mem_req_dropped", {511'b0, m_mvalid}, 512'd0);
        for (int k = 0; k < n_ord; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) step();
            if (mode == 4 && k == 1) begin
                kill = 1'b1;
                step();
                kill = 1'b0;
            end
            if (mode == 7 && k == 1) begin
                rst = 1'b1;
                step();
                chk("rst_busy", {511'b0, m_busy}, 512'd0);
                chk("rst_ready", {511'b0, m_ready}, 512'd1);
                chk("rst_fill_data", m_fdata, 512'd0);
                rst = 1'b0;
            end
            resp_valid = 1'b1; resp_beat = 2'(ord[k]); resp_data = dat[k];
            line = (line & ~(bmask << (ord[k] * bw))) | (({384'b0, dat[k]} & bmask) << (ord[k] * bw));
            if (k == n_ord - 1) begin
                t_last = cyc;
                if (mode == 5) kill = 1'b1;
                if (mode == 0 || mode == 6) begin
                    e.way = ew; e.pa = la; e.data = line; e.cyc = t_last + 1;
                    sb.push_back(e);
                end
            end
            step();
            resp_valid = 1'b0; kill = 1'b0;
        end
        if (mode == 0 || mode == 6) begin
            if (d == 0 && !gaps && n_ord == nb) chk("fill_latency", 512'(t_last + 1 - c0), 512'(2 + nb));
            chk("write_busy", {511'b0, m_busy}, 512'd1);
            kill = (mode == 6);
            step();
            kill = 1'b0;
            chk("after_write_ready", {511'b0, m_ready}, 512'd1);
        end else begin
            chk("drained_busy", {511'b0, m_busy}, 512'd0);
        end
    endtask

    initial begin
        repeat (3) step();
        chk("reset_ready", {511'b0, m_ready}, 512'd1);
        chk("reset_mvalid", {511'b0, m_mvalid}, 512'd0);
        chk("reset_fvalid", {511'b0, m_fvalid}, 512'd0);
        chk("reset_busy", {511'b0, m_busy}, 512'd0);
        chk("reset_fdata", m_fdata, 512'd0);
        rst = 1'b0;
        step();

        // T1 / T2: in-order and reversed beats, same line
        n_ord = 2; ord[0] = 0; ord[1] = 1;
        dat[0] = 128'h0000_0000_0000_0000_AAAA_AAAA_1111_0000;
        dat[1] = 128'h0000_0000_0000_0000_BBBB_BBBB_2222_0001;
        run_txn(0, 26'h1234567, 3'd2, 0, 1'b0);
        ord[0] = 1; ord[1] = 0;
        dat[0] = 128'h0000_0000_0000_0000_BBBB_BBBB_2222_0001;
        dat[1] = 128'h0000_0000_0000_0000_AAAA_AAAA_1111_0000;
        run_txn(0, 26'h1234567, 3'd2, 1, 1'b0);
        // T3, T4, T5 then a clean refill
        make_order(1'b0); run_txn(2, 26'h0ABCDEF, 3'd1, 1, 1'b0);
        make_order(1'b0); run_txn(4, 26'h0ABCDEF, 3'd3, 0, 1'b0);
        make_order(1'b0); run_txn(7, 26'h3FFFFFF, 3'd0, 0, 1'b0);
        make_order(1'b0); run_txn(0, 26'h3FFFFFF, 3'd3, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            make_order($urandom_range(0, 3) == 0);
            run_txn($urandom_range(0, 7), 26'($urandom), 3'($urandom), $urandom_range(0, 2), 1'b1);
        end

        // T6: wide build, beats 3,0,2,1
        wait_idle();
        cfg = 1'b1;
        step();
        n_ord = 4; ord[0] = 3; ord[1] = 0; ord[2] = 2; ord[3] = 1;
        for (int i = 0; i < 4; i++) dat[i] = {$urandom, $urandom, $urandom, $urandom};
        run_txn(0, 26'h2345678, 3'd6, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            make_order($urandom_range(0, 3) == 0);
            run_txn($urandom_range(0, 7), 26'($urandom), 3'($urandom), $urandom_range(0, 2), 1'b1);
        end
        wait_idle();
        repeat (3) step();
        chk("scoreboard_empty", 512'(sb.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
